// File: rtl/cp0_exc_unit.sv
// CP0 register file and precise-exception arbiter at MEM; flush/target PC are combinational, state commits next edge.
// stall_i freezes every commit and mtc0 write (Count/Random/IP sampling keep running) while flush_o still asserts.
module cp0_exc_unit #(
    parameter int          HW_INT_NUM   = 6,
    parameter int          TLB_LINE_NUM = 16,
    parameter int          COUNT_DIV    = 2,
    parameter bit          TI_ON_IP7    = 1'b1,
    parameter logic [31:0] EBASE_RESET  = 32'h80000000,
    parameter logic [31:0] PRID_VAL     = 32'h00018003
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_i,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [2:0]            wsel_i,
    input  logic [31:0]           wdata_i,
    input  logic [4:0]            raddr_i,
    input  logic [2:0]            rsel_i,
    output logic [31:0]           rdata_o,
    input  logic [HW_INT_NUM-1:0] int_i,
    input  logic [8:0]            exc_req_i,
    input  logic [31:0]           pc_i,
    input  logic                  in_ds_i,
    input  logic [31:0]           mem_addr_i,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           count_o,
    output logic [31:0]           random_o,
    output logic                  timer_int_o,
    output logic                  int_take_o,
    output logic                  flush_o,
    output logic [31:0]           exc_pc_o
);
    localparam int             WW        = $clog2(TLB_LINE_NUM);
    localparam logic [WW-1:0]  RND_MAX   = WW'(TLB_LINE_NUM - 1);
    localparam int             PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(COUNT_DIV - 1);

    logic [31:0]   status, epc, badvaddr, count, compare, ebase;
    logic          bd, ti, iv, wp;
    logic [5:0]    ip_hw;
    logic [1:0]    ip_sw;
    logic [4:0]    exccode;
    logic [PW-1:0] presc;
    logic [WW-1:0] random, wired;

    logic [7:0]  ip;
    logic        pending, win_eret, commit, exc_take, eret_take, bad_pc, bad_mem;
    logic [3:0]  win_idx;
    logic [4:0]  exc_code;
    logic        wr, wr_sel0, wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_wired, wr_ebase;
    logic        cnt_tick;
    logic [31:0] cnt_inc;

    assign ip          = {ip_hw[5] | (TI_ON_IP7 & ti), ip_hw[4:0], ip_sw};
    assign cause_o     = {bd, ti, 6'b0, iv, wp, 6'b0, ip, 1'b0, exccode, 2'b0};
    assign status_o    = status;
    assign epc_o       = epc;
    assign count_o     = count;
    assign random_o    = {{(32-WW){1'b0}}, random};
    assign timer_int_o = ti;

    // With TI kept off IP7 the timer is still maskable through IM7 on its own.
    assign pending = status[0] & ~status[1]
                   & ((|(status[15:8] & ip)) | (~TI_ON_IP7 & ti & status[15]));

    // Request bit order already matches priority: lowest set index wins.
    always_comb begin
        win_idx = 4'd9;
        for (int i = 8; i >= 0; i--) begin
            if (exc_req_i[i]) win_idx = 4'(i);
        end
    end

    always_comb begin
        exc_code = 5'd0;
        if (!pending) begin
            case (win_idx)
                4'd0, 4'd1: exc_code = 5'd4;
                4'd2:       exc_code = 5'd10;
                4'd3:       exc_code = 5'd8;
                4'd4:       exc_code = 5'd9;
                4'd5:       exc_code = 5'd5;
                4'd6:       exc_code = 5'd12;
                4'd7:       exc_code = 5'd13;
                default:    exc_code = 5'd0;
            endcase
        end
    end

    assign win_eret   = ~pending & (win_idx == 4'd8);
    assign bad_pc     = ~pending & (win_idx == 4'd0);
    assign bad_mem    = ~pending & ((win_idx == 4'd1) | (win_idx == 4'd5));
    assign flush_o    = pending | (|exc_req_i);
    assign commit     = flush_o & ~stall_i;
    assign exc_take   = commit & ~win_eret;
    assign eret_take  = commit & win_eret;
    assign int_take_o = pending & ~stall_i;

    always_comb begin
        exc_pc_o = 32'h0;
        if (flush_o) begin
            if (win_eret)       exc_pc_o = epc;
            else if (status[22]) exc_pc_o = 32'hBFC00380;
            else                exc_pc_o = ebase + 32'h180;
        end
    end

    assign wr         = we_i & ~stall_i;
    assign wr_sel0    = wr & (wsel_i == 3'd0);
    assign wr_count   = wr_sel0 & (waddr_i == 5'd9);
    assign wr_compare = wr_sel0 & (waddr_i == 5'd11);
    assign wr_status  = wr_sel0 & (waddr_i == 5'd12);
    assign wr_cause   = wr_sel0 & (waddr_i == 5'd13);
    assign wr_epc     = wr_sel0 & (waddr_i == 5'd14);
    assign wr_wired   = wr_sel0 & (waddr_i == 5'd6);
    assign wr_ebase   = wr & (wsel_i == 3'd1) & (waddr_i == 5'd15);

    assign cnt_tick = (presc == PRESC_MAX);
    assign cnt_inc  = count + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status   <= 32'h00400000;
            epc      <= 32'h0;
            badvaddr <= 32'h0;
            count    <= 32'h0;
            compare  <= 32'h0;
            ebase    <= EBASE_RESET;
            bd       <= 1'b0;
            ti       <= 1'b0;
            iv       <= 1'b0;
            wp       <= 1'b0;
            ip_hw    <= 6'h0;
            ip_sw    <= 2'h0;
            exccode  <= 5'h0;
            presc    <= '0;
            random   <= RND_MAX;
            wired    <= '0;
        end else begin
            ip_hw <= 6'(int_i);

            if (wr_count) begin
                count <= wdata_i;
                presc <= '0;
            end else if (cnt_tick) begin
                count <= cnt_inc;
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end

            if (wr_compare) begin
                compare <= wdata_i;
                ti      <= 1'b0;
            end else if (!wr_count && cnt_tick && (cnt_inc == compare)) begin
                ti <= 1'b1;
            end

            if (wr_wired) begin
                wired  <= wdata_i[WW-1:0];
                random <= RND_MAX;
            end else if ((wired >= RND_MAX) || (random == wired)) begin
                random <= RND_MAX;
            end else begin
                random <= random - 1'b1;
            end

            if (wr_status) status <= wdata_i;
            if (wr_cause) begin
                ip_sw <= wdata_i[9:8];
                iv    <= wdata_i[23];
                wp    <= wdata_i[22];
            end
            if (wr_epc)   epc         <= wdata_i;
            if (wr_ebase) ebase[29:0] <= wdata_i[29:0];

            // Placed after the mtc0 writes so the exception owns overlapping bits.
            if (exc_take) begin
                status[1] <= 1'b1;
                exccode   <= exc_code;
                if (!status[1]) begin
                    epc <= in_ds_i ? (pc_i - 32'd4) : pc_i;
                    bd  <= in_ds_i;
                end
                if (bad_pc)       badvaddr <= pc_i;
                else if (bad_mem) badvaddr <= mem_addr_i;
            end else if (eret_take) begin
                status[1] <= 1'b0;
            end
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        case (raddr_i)
            5'd1:  if (rsel_i == 3'd0) rdata_o = random_o;
            5'd6:  if (rsel_i == 3'd0) rdata_o = {{(32-WW){1'b0}}, wired};
            5'd8:  if (rsel_i == 3'd0) rdata_o = badvaddr;
            5'd9:  if (rsel_i == 3'd0) rdata_o = count;
            5'd11: if (rsel_i == 3'd0) rdata_o = compare;
            5'd12: if (rsel_i == 3'd0) rdata_o = status;
            5'd13: if (rsel_i == 3'd0) rdata_o = cause_o;
            5'd14: if (rsel_i == 3'd0) rdata_o = epc;
            5'd15: begin
                if (rsel_i == 3'd0)      rdata_o = PRID_VAL;
                else if (rsel_i == 3'd1) rdata_o = ebase;
            end
            5'd16: if (rsel_i == 3'd0) rdata_o = 32'h00008000;
            default: rdata_o = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed bench for cp0_exc_unit: stimulus queues expectations, a negedge monitor pops and compares.
module tb_cp0_exc_unit;
    logic        clk, rst, stall_i, we_i, in_ds_i;
    logic [4:0]  waddr_i, raddr_i;
    logic [2:0]  wsel_i, rsel_i;
    logic [31:0] wdata_i, rdata_o, pc_i, mem_addr_i;
    logic [5:0]  int_i;
    logic [8:0]  exc_req_i;
    logic [31:0] status_o, cause_o, epc_o, count_o, random_o, exc_pc_o;
    logic        timer_int_o, int_take_o, flush_o;

    cp0_exc_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .we_i(we_i), .waddr_i(waddr_i),
        .wsel_i(wsel_i), .wdata_i(wdata_i), .raddr_i(raddr_i), .rsel_i(rsel_i),
        .rdata_o(rdata_o), .int_i(int_i), .exc_req_i(exc_req_i), .pc_i(pc_i),
        .in_ds_i(in_ds_i), .mem_addr_i(mem_addr_i), .status_o(status_o),
        .cause_o(cause_o), .epc_o(epc_o), .count_o(count_o), .random_o(random_o),
        .timer_int_o(timer_int_o), .int_take_o(int_take_o), .flush_o(flush_o),
        .exc_pc_o(exc_pc_o)
    );

    typedef struct {
        string       nm;
        int          src;
        logic [31:0] exp;
    } chk_t;
    typedef struct {
        logic [31:0] pc;
        logic        take;
    } fl_t;

    chk_t cq[$];
    fl_t  fq[$];
    int   total = 0;
    int   bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pick(input int src);
        case (src)
            0:       return rdata_o;
            1:       return status_o;
            2:       return cause_o;
            3:       return epc_o;
            4:       return count_o;
            5:       return random_o;
            6:       return {31'b0, timer_int_o};
            7:       return {31'b0, flush_o};
            default: return {31'b0, int_take_o};
        endcase
    endfunction

    always @(negedge clk) begin
        chk_t        c;
        fl_t         f;
        logic [31:0] act;
        while (cq.size() > 0) begin
            c   = cq.pop_front();
            act = pick(c.src);
            total++;
            if (act !== c.exp) begin
                bad++;
                $display("FAIL %s: got %h expected %h", c.nm, act, c.exp);
            end
        end
        if (flush_o) begin
            total++;
            if (fq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_flush: got exc_pc %h expected no flush", exc_pc_o);
            end else begin
                f = fq.pop_front();
                if (exc_pc_o !== f.pc || int_take_o !== f.take) begin
                    bad++;
                    $display("FAIL flush_target: got pc %h take %b expected pc %h take %b",
                             exc_pc_o, int_take_o, f.pc, f.take);
                end
            end
        end else if (fq.size() > 0) begin
            f = fq.pop_front();
            total++;
            bad++;
            $display("FAIL missing_flush: got flush 0 expected flush to %h", f.pc);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int src, input logic [31:0] exp);
        chk_t c;
        c.nm = nm; c.src = src; c.exp = exp;
        cq.push_back(c);
    endtask

    task automatic expflush(input logic [31:0] pc, input logic take);
        fl_t f;
        f.pc = pc; f.take = take;
        fq.push_back(f);
    endtask

    task automatic rd(input logic [4:0] a, input logic [2:0] s, input string nm, input logic [31:0] e);
        raddr_i = a; rsel_i = s;
        chk(nm, 0, e);
        cyc();
    endtask

    task automatic wr(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; wsel_i = s; wdata_i = d;
        cyc();
        we_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall_i = 0; we_i = 0; waddr_i = 0; wsel_i = 0; wdata_i = 0;
        raddr_i = 0; rsel_i = 0; int_i = 0; exc_req_i = 0; pc_i = 0; in_ds_i = 0; mem_addr_i = 0;
        cyc(); cyc();

        // reset state
        chk("rst_status", 1, 32'h00400000);
        chk("rst_random", 5, 32'h0000000F);
        chk("rst_cause", 2, 32'h0);
        chk("rst_epc", 3, 32'h0);
        chk("rst_flush", 7, 32'h0);
        rd(5'd15, 3'd1, "rst_ebase", 32'h80000000);
        rd(5'd15, 3'd0, "prid", 32'h00018003);
        rd(5'd16, 3'd0, "config", 32'h00008000);
        rd(5'd15, 3'd2, "bad_sel", 32'h0);
        rst = 1'b0;
        cyc();

        // hardware interrupt with BEV=1
        wr(5'd12, 3'd0, 32'h0040FF01);
        int_i = 6'b000001;
        cyc();
        expflush(32'hBFC00380, 1'b1);
        chk("int_cause_ip2", 2, 32'h00000400);
        pc_i = 32'h80000100;
        int_i = 6'b0;
        cyc();
        chk("int_status_exl", 1, 32'h0040FF03);
        chk("int_cause_code", 2, 32'h0);
        chk("int_epc", 3, 32'h80000100);
        chk("int_no_flush", 7, 32'h0);

        // RI in delay slot with BEV=0
        wr(5'd12, 3'd0, 32'h0);
        exc_req_i = 9'h004; pc_i = 32'h80001004; in_ds_i = 1'b1;
        expflush(32'h80000180, 1'b0);
        cyc();
        exc_req_i = 0; in_ds_i = 0;
        chk("ri_epc", 3, 32'h80001000);
        chk("ri_cause", 2, 32'h80000028);
        chk("ri_status", 1, 32'h00000002);

        // nested AdES under EXL, then eret
        wr(5'd12, 3'd0, 32'h00000002);
        exc_req_i = 9'h020; mem_addr_i = 32'h00000013; pc_i = 32'h80002000;
        expflush(32'h80000180, 1'b0);
        cyc();
        exc_req_i = 0;
        chk("ades_epc_kept", 3, 32'h80001000);
        chk("ades_cause", 2, 32'h80000014);
        rd(5'd8, 3'd0, "ades_badvaddr", 32'h00000013);
        exc_req_i = 9'h100;
        expflush(32'h80001000, 1'b0);
        cyc();
        exc_req_i = 0;
        chk("eret_status", 1, 32'h0);

        // stall holds commit and mtc0
        stall_i = 1'b1; exc_req_i = 9'h008; pc_i = 32'h80003000;
        we_i = 1'b1; waddr_i = 5'd14; wsel_i = 3'd0; wdata_i = 32'hDEADBEEF;
        expflush(32'h80000180, 1'b0);
        cyc();
        we_i = 1'b0;
        expflush(32'h80000180, 1'b0);
        chk("stall_epc", 3, 32'h80001000);
        chk("stall_status", 1, 32'h0);
        chk("stall_no_take", 8, 32'h0);
        cyc();
        stall_i = 1'b0;
        expflush(32'h80000180, 1'b0);
        cyc();
        exc_req_i = 0;
        chk("sys_epc", 3, 32'h80003000);
        chk("sys_status", 1, 32'h00000002);
        chk("sys_cause", 2, 32'h00000020);

        // timer: Compare=5, Count=0, two clocks per tick
        wr(5'd11, 3'd0, 32'd5);
        wr(5'd9, 3'd0, 32'd0);
        chk("cnt_start", 4, 32'h0);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk($sformatf("ti_cyc%0d", i), 6, (i == 10) ? 32'h1 : 32'h0);
        end
        chk("cnt_at_ti", 4, 32'd5);
        chk("ti_cause", 2, 32'h40008020);
        wr(5'd11, 3'd0, 32'd100);
        chk("ti_clear", 6, 32'h0);
        chk("ti_clear_cause", 2, 32'h00000020);

        // Cause write mask, EBase write and EBase-based vector
        wr(5'd13, 3'd0, 32'hFFFFFFFF);
        chk("cause_mask", 2, 32'h00C00320);
        wr(5'd13, 3'd0, 32'h0);
        wr(5'd15, 3'd1, 32'hFFFFFFFF);
        rd(5'd15, 3'd1, "ebase_wr", 32'hBFFFFFFF);
        exc_req_i = 9'h080;
        expflush(32'hC000017F, 1'b0);
        cyc();
        exc_req_i = 0;
        chk("tr_cause", 2, 32'h00000034);

        // Random cycling with Wired=4
        wr(5'd6, 3'd0, 32'd4);
        chk("rnd_reload", 5, 32'd15);
        for (int k = 1; k <= 13; k++) begin
            cyc();
            chk($sformatf("rnd_k%0d", k), 5, (k <= 11) ? 32'(15 - k) : ((k == 12) ? 32'd15 : 32'd14));
        end
        rd(5'd6, 3'd0, "wired", 32'd4);

        // async reset mid-sequence, checked before any clock edge
        cyc(); cyc();
        rst = 1'b1;
        chk("arst_status", 1, 32'h00400000);
        chk("arst_random", 5, 32'h0000000F);
        chk("arst_epc", 3, 32'h0);
        chk("arst_count", 4, 32'h0);
        chk("arst_cause", 2, 32'h0);
        raddr_i = 5'd15; rsel_i = 3'd1;
        chk("arst_ebase", 0, 32'h80000000);
        cyc();
        rst = 1'b0;
        cyc(); cyc();

        if (fq.size() != 0 || cq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL leftover: got %0d pending expected 0", fq.size() + cq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
